adc_osr_filter: RTL and testbench
=================================

Name: adc_osr_filter

Overview:
- Oversampling decimator placed after the 10-bit SAR ADC core.
- Accumulates N consecutive conversion results (N = 1, 4, 16, 64 or 256, chosen by osr_mode_in).
- Emits one 14-bit normalized result, right-aligned in a 16-bit bus, together with a one-cycle completion flag.
- Clocked by the ADC's data-valid strobe, so every rising edge captures exactly one sample.

Parameters:
- None. Widths are fixed: 10-bit input, 16-bit output, 18-bit accumulator, 8-bit sample counter.

Ports:
- data_valid_strobe  input  1  Clock. One rising edge per valid ADC sample on data_in.
- rst_n  input  1  Synchronous reset, active-HIGH. Keeps the codebase name despite the _n suffix; asserted = 1.
- osr_mode_in  input  3  Oversampling ratio select: 0 = 1x, 1 = 4x, 2 = 16x, 3 = 64x, 4 = 256x, 5..7 = treated as 0.
- data_in  input  10  Unsigned ADC sample, sampled on the rising edge.
- data_out  output  16  Normalized result; bits [15:14] always 0.
- conversion_finished_osr_out  output  1  High for exactly one cycle on the edge that produces a new data_out.

Behaviour:
- All state changes on the rising edge of data_valid_strobe only. No combinational input-to-output paths; all outputs are registered.
- Reset (rst_n = 1 at an edge): data_out = 0, conversion_finished_osr_out = 0, accumulator = 0, counter = 0, registered mode = 0. Reset has priority over everything.
- Reset mid-window discards the partial sum. The first edge after reset release is sample 1 of a new window.
- Registered mode (mode_q) tracks osr_mode_in each edge. If osr_mode_in != mode_q:
  - the partial window is discarded;
  - the current sample becomes sample 1 of a new window under the new mode;
  - no completion is emitted on that edge unless the new mode is 1x.
- Window length N: 1, 4, 16, 64, 256 for modes 0, 1, 2, 3, 4.
- Per edge, with sum = accumulator + data_in (18 bits, zero-extended):
  - If counter == N-1 (end of window):
    - data_out <= normalize(sum)
    - conversion_finished_osr_out <= 1
    - accumulator <= 0
    - counter <= 0
  - Otherwise:
    - accumulator <= sum
    - counter <= counter + 1
    - conversion_finished_osr_out <= 0
    - data_out holds its value.
- Normalization to 14 bits, zero-extended to 16 bits:
  - 1x: data_in << 4
  - 4x: sum << 2
  - 16x: sum
  - 64x: sum >> 2 (truncate)
  - 256x: sum >> 4 (truncate)
- No overflow is possible. The maximum 256x sum is 0x3FF00, which normalizes to 0x3FF0.
- Latency: the result appears on the same edge that captures the Nth sample (registered, available after that edge).
- In 1x mode, conversion_finished_osr_out stays 1 continuously and data_out updates every edge.
- data_out is never cleared between windows; only reset clears it.

Test Plan:
- Reset, then mode 0 with data_in = 0x111 then 0x222 -> data_out = 0x1110, then 0x2220; finished = 1 on each edge.
- Mode 1, samples 0,1,2,3 -> after 4th edge data_out = 0x0018 and finished pulses once. For 3 edges before, finished = 0 and data_out holds its prior value.
- Reset, mode 2:
  - 16 x 0x090 -> data_out = 0x0900;
  - immediately 16 samples 0x090+i (i = 0..15) -> data_out = 0x0978.
- Mode 3, samples 0..63 -> 0x01F8. Then mode 4, samples 0..255 -> 0x07F8. Then mode 0, sample 0x123 -> 0x1230 on the next edge.
- Mode 4, 256 x 0x3FF -> data_out = 0x3FF0 (no overflow). Also assert reset after 100 samples -> outputs 0, and the next full window of 256 x 0x3FF still yields 0x3FF0.
- Switch mode 2 -> 3 after 5 samples -> the partial sum is discarded and the first completion arrives 64 edges after the switch. Modes 5..7 behave exactly as mode 0.

Source files
------------

// File: rtl/adc_osr_filter_if.sv
// Sample/result bundle between the SAR ADC core side and the oversampling decimator.
// The master drives mode and samples; the slave returns the normalized result and completion flag.
interface adc_osr_filter_if;
  logic [2:0]  osr_mode_in;
  logic [9:0]  data_in;
  logic [15:0] data_out;
  logic        conversion_finished_osr_out;

  modport master (
    output osr_mode_in,
    output data_in,
    input  data_out,
    input  conversion_finished_osr_out
  );

  modport slave (
    input  osr_mode_in,
    input  data_in,
    output data_out,
    output conversion_finished_osr_out
  );
endinterface

// File: rtl/adc_osr_filter.sv
// Oversampling decimator: sums 1/4/16/64/256 ADC samples and emits a 14-bit normalized result.
// Clocked by the ADC data-valid strobe, so every rising edge is exactly one sample.
module adc_osr_filter (
  input  logic               data_valid_strobe,
  input  logic               rst_n,
  adc_osr_filter_if.slave    bus
);

  logic [2:0]  mode_q;
  logic [2:0]  mode_eff;
  logic [17:0] acc_q;
  logic [7:0]  cnt_q;
  logic [15:0] data_out_q;
  logic        fin_q;

  logic        restart;
  logic [17:0] acc_eff;
  logic [7:0]  cnt_eff;
  logic [7:0]  n_last;
  logic [17:0] sum;
  logic [15:0] norm;

  // Unused encodings 5..7 fold onto 1x, so moving between them never restarts a window.
  always_comb begin
    mode_eff = bus.osr_mode_in;
    if (bus.osr_mode_in > 3'd4) mode_eff = 3'd0;
  end

  always_comb begin
    n_last = 8'd0;
    case (mode_eff)
      3'd1:    n_last = 8'd3;
      3'd2:    n_last = 8'd15;
      3'd3:    n_last = 8'd63;
      3'd4:    n_last = 8'd255;
      default: n_last = 8'd0;
    endcase
  end

  // A mode change turns the current sample into sample 1 of a fresh window.
  always_comb begin
    restart = (mode_eff != mode_q);
    acc_eff = restart ? 18'd0 : acc_q;
    cnt_eff = restart ? 8'd0  : cnt_q;
    sum     = acc_eff + {8'd0, bus.data_in};
  end

  always_comb begin
    norm = 16'd0;
    case (mode_eff)
      3'd1:    norm = {2'b00, sum[11:0], 2'b00};
      3'd2:    norm = {2'b00, sum[13:0]};
      3'd3:    norm = {2'b00, sum[15:2]};
      3'd4:    norm = {2'b00, sum[17:4]};
      default: norm = {2'b00, bus.data_in, 4'b0000};
    endcase
  end

  always_ff @(posedge data_valid_strobe) begin
    if (rst_n) begin
      mode_q     <= 3'd0;
      acc_q      <= 18'd0;
      cnt_q      <= 8'd0;
      data_out_q <= 16'd0;
      fin_q      <= 1'b0;
    end else begin
      mode_q <= mode_eff;
      if (cnt_eff == n_last) begin
        data_out_q <= norm;
        fin_q      <= 1'b1;
        acc_q      <= 18'd0;
        cnt_q      <= 8'd0;
      end else begin
        acc_q <= sum;
        cnt_q <= cnt_eff + 8'd1;
        fin_q <= 1'b0;
      end
    end
  end

  assign bus.data_out                    = data_out_q;
  assign bus.conversion_finished_osr_out = fin_q;

endmodule

// File: tb/tb_adc_osr_filter.sv
// Directed bench for adc_osr_filter: a vector table for short sequences plus
// hand-written long windows, reset-in-window and mode-switch cases.
module tb_adc_osr_filter;

  logic clk;
  logic rst;
  adc_osr_filter_if bus ();

  adc_osr_filter dut (
    .data_valid_strobe (clk),
    .rst_n             (rst),
    .bus               (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        rst;
    logic [2:0]  mode;
    logic [9:0]  data;
    logic [15:0] exp_out;
    logic        exp_fin;
  } vec_t;

  vec_t vecs [12];

  task automatic step(input logic r, input logic [2:0] m, input logic [9:0] d);
    @(negedge clk);
    rst             = r;
    bus.osr_mode_in = m;
    bus.data_in     = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] exp_out, input logic exp_fin);
    checks++;
    if (bus.data_out !== exp_out || bus.conversion_finished_osr_out !== exp_fin) begin
      failures++;
      $display("FAIL %s: data_out=%h fin=%b, required data_out=%h fin=%b",
               name, bus.data_out, bus.conversion_finished_osr_out, exp_out, exp_fin);
    end
  endtask

  initial begin
    rst             = 1'b1;
    bus.osr_mode_in = 3'd0;
    bus.data_in     = 10'd0;

    vecs[0]  = '{1'b1, 3'd0, 10'h000, 16'h0000, 1'b0};
    vecs[1]  = '{1'b0, 3'd0, 10'h111, 16'h1110, 1'b1};
    vecs[2]  = '{1'b0, 3'd0, 10'h222, 16'h2220, 1'b1};
    vecs[3]  = '{1'b0, 3'd1, 10'h000, 16'h2220, 1'b0};
    vecs[4]  = '{1'b0, 3'd1, 10'h001, 16'h2220, 1'b0};
    vecs[5]  = '{1'b0, 3'd1, 10'h002, 16'h2220, 1'b0};
    vecs[6]  = '{1'b0, 3'd1, 10'h003, 16'h0018, 1'b1};
    vecs[7]  = '{1'b0, 3'd5, 10'h0AB, 16'h0AB0, 1'b1};
    vecs[8]  = '{1'b0, 3'd7, 10'h3FF, 16'h3FF0, 1'b1};
    vecs[9]  = '{1'b0, 3'd6, 10'h001, 16'h0010, 1'b1};
    vecs[10] = '{1'b0, 3'd0, 10'h123, 16'h1230, 1'b1};
    vecs[11] = '{1'b1, 3'd1, 10'h3FF, 16'h0000, 1'b0};

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].rst, vecs[i].mode, vecs[i].data);
      check($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_fin);
    end

    // 16x: constant window, then a ramp window immediately after
    step(1'b1, 3'd2, 10'h000);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 3'd2, 10'h090);
      if (i == 14) check("osr16_mid", 16'h0000, 1'b0);
    end
    check("osr16_const", 16'h0900, 1'b1);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 3'd2, 10'(10'h090 + i));
      if (i == 0) check("osr16_hold", 16'h0900, 1'b0);
    end
    check("osr16_ramp", 16'h0978, 1'b1);

    // 64x ramp, 256x ramp, back to 1x
    for (int i = 0; i < 64; i++) begin
      step(1'b0, 3'd3, 10'(i));
      if (i == 62) check("osr64_mid", 16'h0978, 1'b0);
    end
    check("osr64_ramp", 16'h01F8, 1'b1);
    for (int i = 0; i < 256; i++) begin
      step(1'b0, 3'd4, 10'(i));
      if (i == 254) check("osr256_mid", 16'h01F8, 1'b0);
    end
    check("osr256_ramp", 16'h07F8, 1'b1);
    step(1'b0, 3'd0, 10'h123);
    check("back_to_1x", 16'h1230, 1'b1);

    // 256x full scale, then reset after 100 samples of a new window
    for (int i = 0; i < 256; i++) step(1'b0, 3'd4, 10'h3FF);
    check("osr256_fullscale", 16'h3FF0, 1'b1);
    for (int i = 0; i < 100; i++) step(1'b0, 3'd4, 10'h3FF);
    check("pre_reset_hold", 16'h3FF0, 1'b0);
    step(1'b1, 3'd4, 10'h3FF);
    check("mid_window_reset", 16'h0000, 1'b0);
    for (int i = 0; i < 256; i++) begin
      step(1'b0, 3'd4, 10'h3FF);
      if (i == 254) check("post_reset_mid", 16'h0000, 1'b0);
    end
    check("post_reset_full", 16'h3FF0, 1'b1);

    // 16x partial window abandoned by switching to 64x
    for (int i = 0; i < 5; i++) step(1'b0, 3'd2, 10'h100);
    check("partial16", 16'h3FF0, 1'b0);
    begin
      int early;
      early = 0;
      for (int i = 0; i < 64; i++) begin
        step(1'b0, 3'd3, 10'h001);
        if (i < 63 && bus.conversion_finished_osr_out !== 1'b0) early++;
      end
      checks++;
      if (early != 0) begin
        failures++;
        $display("FAIL switch_no_early: early completions=%0d, required 0", early);
      end
    end
    check("switch_64x", 16'h0010, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
